// File: rtl/operand_capture.sv
// operand_capture
//   Collects NUM_OPS signed decimal operands from a keypad. Each operand is
//   typed as up to MAX_DIGITS decimal digits with an optional sign toggle,
//   then committed with enter. Once every operand has been captured the
//   block parks in FULL until the consumer acknowledges.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   key_value    keypad code: 0-9 digit, A enter, B backspace, C clear-all,
//                D negate, E/F ignored
//   key_pressed  level, high while a key is held
//   ops_ack      consumer has taken all operands (honoured only in FULL)
//   ops          packed operands, operand i at [i*WIDTH +: WIDTH]
//   ops_valid    per-operand captured flag
//   all_ready    high while in FULL
//   op_index     operand currently being entered
//   entry_mag    unsigned magnitude of the entry in progress
//   entry_neg    sign of the entry in progress
//   digit_count  digits in the entry in progress
//   key_err      one-cycle pulse when a key is rejected
module operand_capture #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int NUM_OPS    = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [3:0]                                       key_value,
    input  logic                                             key_pressed,
    input  logic                                             ops_ack,
    output logic [NUM_OPS*WIDTH-1:0]                         ops,
    output logic [NUM_OPS-1:0]                               ops_valid,
    output logic                                             all_ready,
    output logic [((NUM_OPS > 1) ? $clog2(NUM_OPS) : 1)-1:0] op_index,
    output logic [WIDTH-1:0]                                 entry_mag,
    output logic                                             entry_neg,
    output logic [$clog2(MAX_DIGITS+1)-1:0]                  digit_count,
    output logic                                             key_err
);

    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    // Four extra bits hold mag*10+d without overflow before the range test.
    localparam int EXT_W = WIDTH + 4;

    localparam logic [EXT_W-1:0] TEN_EXT  = EXT_W'(10);
    localparam logic [EXT_W-1:0] MAX_POS  = EXT_W'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [WIDTH-1:0] TEN      = WIDTH'(10);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_BKSP   = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;
    localparam logic [3:0] KEY_NEGATE = 4'hD;

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nx;

    logic key_prev;
    // Cleared while a key is held through reset, so that press cannot be
    // mistaken for a fresh one; re-armed as soon as the key is seen released.
    logic key_armed;
    logic key_evt;

    logic [NUM_OPS*WIDTH-1:0] ops_nx;
    logic [NUM_OPS-1:0]       valid_nx;
    logic [IDX_W-1:0]         idx_nx;
    logic [WIDTH-1:0]         mag_nx;
    logic                     neg_nx;
    logic [CNT_W-1:0]         cnt_nx;
    logic                     err_nx;

    logic [EXT_W-1:0]         mag_ext;
    logic                     digit_ok;
    logic signed [WIDTH-1:0]  op_val;

    // Two's complement value of a sign/magnitude entry.
    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                           input logic             neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(mag);
        return neg ? -s : s;
    endfunction

    assign key_evt  = key_pressed & ~key_prev & key_armed;
    assign mag_ext  = {4'b0000, entry_mag} * TEN_EXT + {{WIDTH{1'b0}}, key_value};
    assign digit_ok = (digit_count < MAX_CNT) && (mag_ext <= MAX_POS);
    assign op_val   = apply_sign(entry_mag, entry_neg);

    always_comb begin
        state_nx = state;
        ops_nx   = ops;
        valid_nx = ops_valid;
        idx_nx   = op_index;
        mag_nx   = entry_mag;
        neg_nx   = entry_neg;
        cnt_nx   = digit_count;
        err_nx   = 1'b0;

        if (key_evt && key_value == KEY_CLEAR) begin
            // Clear-all wins in either state, including over a same-cycle ack.
            state_nx = ENTRY;
            ops_nx   = '0;
            valid_nx = '0;
            idx_nx   = '0;
            mag_nx   = '0;
            neg_nx   = 1'b0;
            cnt_nx   = '0;
        end else if (state == FULL) begin
            // Any other key is dropped silently here; ops keep their values.
            if (ops_ack) begin
                state_nx = ENTRY;
                valid_nx = '0;
                idx_nx   = '0;
                mag_nx   = '0;
                neg_nx   = 1'b0;
                cnt_nx   = '0;
            end
        end else if (key_evt) begin
            if (key_value <= 4'd9) begin
                if (digit_ok) begin
                    mag_nx = mag_ext[WIDTH-1:0];
                    cnt_nx = digit_count + CNT_W'(1);
                end else begin
                    err_nx = 1'b1;
                end
            end else begin
                case (key_value)
                    KEY_ENTER: begin
                        if (digit_count == '0) begin
                            err_nx = 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_OPS; i++) begin
                                if (op_index == IDX_W'(i)) begin
                                    ops_nx[i*WIDTH +: WIDTH] = op_val;
                                    valid_nx[i]              = 1'b1;
                                end
                            end
                            mag_nx = '0;
                            neg_nx = 1'b0;
                            cnt_nx = '0;
                            if (op_index == LAST_IDX) begin
                                state_nx = FULL;
                            end else begin
                                idx_nx = op_index + IDX_W'(1);
                            end
                        end
                    end
                    KEY_BKSP: begin
                        // With no digits left, backspace only drops the sign.
                        if (digit_count == '0) begin
                            neg_nx = 1'b0;
                        end else begin
                            mag_nx = entry_mag / TEN;
                            cnt_nx = digit_count - CNT_W'(1);
                        end
                    end
                    KEY_NEGATE: neg_nx = ~entry_neg;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ENTRY;
            key_prev    <= 1'b0;
            key_armed   <= ~key_pressed;
            ops         <= '0;
            ops_valid   <= '0;
            all_ready   <= 1'b0;
            op_index    <= '0;
            entry_mag   <= '0;
            entry_neg   <= 1'b0;
            digit_count <= '0;
            key_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            key_prev    <= key_pressed;
            key_armed   <= key_armed | ~key_pressed;
            ops         <= ops_nx;
            ops_valid   <= valid_nx;
            all_ready   <= (state_nx == FULL);
            op_index    <= idx_nx;
            entry_mag   <= mag_nx;
            entry_neg   <= neg_nx;
            digit_count <= cnt_nx;
            key_err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_operand_capture.sv
module tb_operand_capture;

    localparam int W  = 8;
    localparam int MD = 3;
    localparam int N  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   key_value = 4'h0;
    logic         key_pressed = 1'b0;
    logic         ops_ack = 1'b0;
    logic [N*W-1:0] ops;
    logic [N-1:0] ops_valid;
    logic         all_ready;
    logic [0:0]   op_index;
    logic [W-1:0] entry_mag;
    logic         entry_neg;
    logic [1:0]   digit_count;
    logic         key_err;

    operand_capture #(.WIDTH(W), .MAX_DIGITS(MD), .NUM_OPS(N)) dut (
        .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed),
        .ops_ack(ops_ack), .ops(ops), .ops_valid(ops_valid), .all_ready(all_ready),
        .op_index(op_index), .entry_mag(entry_mag), .entry_neg(entry_neg),
        .digit_count(digit_count), .key_err(key_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    logic e_err;

    // Behavioural model state, in plain integers.
    int        m_op [N];
    bit [N-1:0] m_valid;
    int        m_idx, m_mag, m_cnt, nv;
    bit        m_neg, m_full, m_err, m_prev, m_armed, evt;
    logic [N*W-1:0] exp_ops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task model_clear_entry();
        m_mag = 0;
        m_neg = 1'b0;
        m_cnt = 0;
    endtask

    task model_step();
        m_err = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N; i++) m_op[i] = 0;
            m_valid = '0;
            m_idx   = 0;
            model_clear_entry();
            m_full  = 1'b0;
            m_prev  = 1'b0;
            m_armed = !key_pressed;
        end else begin
            evt = key_pressed && !m_prev && m_armed;
            if (evt && key_value == 4'hC) begin
                for (int i = 0; i < N; i++) m_op[i] = 0;
                m_valid = '0;
                m_idx   = 0;
                model_clear_entry();
                m_full  = 1'b0;
            end else if (m_full) begin
                if (ops_ack) begin
                    m_valid = '0;
                    m_idx   = 0;
                    model_clear_entry();
                    m_full  = 1'b0;
                end
            end else if (evt) begin
                if (key_value <= 4'd9) begin
                    nv = m_mag * 10 + int'(key_value);
                    if (m_cnt < MD && nv <= (1 << (W - 1)) - 1) begin
                        m_mag = nv;
                        m_cnt++;
                    end else begin
                        m_err = 1'b1;
                    end
                end else if (key_value == 4'hA) begin
                    if (m_cnt == 0) begin
                        m_err = 1'b1;
                    end else begin
                        m_op[m_idx]    = m_neg ? -m_mag : m_mag;
                        m_valid[m_idx] = 1'b1;
                        model_clear_entry();
                        if (m_idx == N - 1) m_full = 1'b1;
                        else m_idx++;
                    end
                end else if (key_value == 4'hB) begin
                    if (m_cnt == 0) m_neg = 1'b0;
                    else begin
                        m_mag = m_mag / 10;
                        m_cnt--;
                    end
                end else if (key_value == 4'hD) begin
                    m_neg = !m_neg;
                end
            end
            m_prev = key_pressed;
            if (!key_pressed) m_armed = 1'b1;
        end
    endtask

    task compare_all();
        for (int i = 0; i < N; i++) exp_ops[i*W +: W] = m_op[i][W-1:0];
        chk("ops",         32'(ops),         32'(exp_ops));
        chk("ops_valid",   32'(ops_valid),   32'(m_valid));
        chk("all_ready",   32'(all_ready),   32'(m_full));
        chk("op_index",    32'(op_index),    32'(m_idx));
        chk("entry_mag",   32'(entry_mag),   32'(m_mag));
        chk("entry_neg",   32'(entry_neg),   32'(m_neg));
        chk("digit_count", 32'(digit_count), 32'(m_cnt));
        chk("key_err",     32'(key_err),     32'(m_err));
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) if (chk_en) compare_all();

    task automatic tick(input logic [3:0] k, input logic kp, input logic ack);
        key_value   = k;
        key_pressed = kp;
        ops_ack     = ack;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k, output logic err);
        tick(k, 1'b1, 1'b0);
        err = key_err;
        tick(k, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ops",   32'(ops), 32'h0);
        chk("reset_valid", 32'(ops_valid), 32'h0);
        chk("reset_ready", 32'(all_ready), 32'h0);
        chk("reset_mag",   32'(entry_mag), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // 1,2,7,enter
        press(4'h1, e_err); press(4'h2, e_err); press(4'h7, e_err); press(4'hA, e_err);
        chk("op0_127",      32'(ops[7:0]), 32'h7F);
        chk("op0_valid",    32'(ops_valid), 32'h1);
        chk("op0_index",    32'(op_index), 32'h1);
        chk("op0_mag_zero", 32'(entry_mag), 32'h0);
        chk("enter_no_err", 32'(e_err), 32'h0);

        // negate,4,5,enter -> -45
        press(4'hD, e_err); press(4'h4, e_err);
        chk("neg_mag", 32'(entry_mag), 32'd4);
        chk("neg_flag", 32'(entry_neg), 32'h1);
        press(4'h5, e_err); press(4'hA, e_err);
        chk("op1_minus45", 32'(ops[15:8]), 32'hD3);
        chk("full_ready",  32'(all_ready), 32'h1);
        chk("full_valid",  32'(ops_valid), 32'h3);
        press(4'h3, e_err);
        chk("full_key_no_err", 32'(e_err), 32'h0);
        chk("full_ops_hold",   32'(ops), 32'hD37F);
        tick(4'h0, 1'b0, 1'b1);
        tick(4'h0, 1'b0, 1'b0);
        chk("ack_valid", 32'(ops_valid), 32'h0);
        chk("ack_index", 32'(op_index), 32'h0);
        chk("ack_ready", 32'(all_ready), 32'h0);
        chk("ack_ops",   32'(ops), 32'hD37F);

        // 1,2,8 -> 128 out of range
        press(4'h1, e_err); press(4'h2, e_err); press(4'h8, e_err);
        chk("range_err_pulse", 32'(e_err), 32'h1);
        chk("range_err_gone",  32'(key_err), 32'h0);
        chk("range_mag",       32'(entry_mag), 32'd12);
        chk("range_cnt",       32'(digit_count), 32'd2);
        press(4'hB, e_err);
        chk("bksp_mag", 32'(entry_mag), 32'd1);
        chk("bksp_cnt", 32'(digit_count), 32'd1);
        press(4'hC, e_err);
        chk("clr_ops", 32'(ops), 32'h0);
        chk("clr_mag", 32'(entry_mag), 32'h0);
        chk("clr_cnt", 32'(digit_count), 32'h0);
        press(4'hA, e_err);
        chk("empty_enter_err", 32'(e_err), 32'h1);

        // digit limit: 1,0,0 then a fourth digit
        press(4'h1, e_err); press(4'h0, e_err); press(4'h0, e_err); press(4'h5, e_err);
        chk("maxdig_err", 32'(e_err), 32'h1);
        chk("maxdig_mag", 32'(entry_mag), 32'd100);
        press(4'hB, e_err);
        chk("maxdig_bksp", 32'(entry_mag), 32'd10);
        press(4'hC, e_err);

        // key held for 10 cycles gives one event
        for (int i = 0; i < 10; i++) tick(4'h5, 1'b1, 1'b0);
        tick(4'h5, 1'b0, 1'b0);
        chk("held_mag", 32'(entry_mag), 32'd5);
        chk("held_cnt", 32'(digit_count), 32'd1);

        press(4'hE, e_err);
        chk("code_e_no_err", 32'(e_err), 32'h0);
        press(4'hF, e_err);
        chk("code_f_no_err", 32'(e_err), 32'h0);
        press(4'hD, e_err); press(4'hA, e_err);
        chk("op0_minus5", 32'(ops[7:0]), 32'hFB);

        // ack in ENTRY ignored
        tick(4'h0, 1'b0, 1'b1);
        tick(4'h0, 1'b0, 1'b0);
        chk("entry_ack_index", 32'(op_index), 32'h1);
        chk("entry_ack_valid", 32'(ops_valid), 32'h1);

        // key with ack in FULL: ack wins, key discarded
        press(4'h9, e_err); press(4'hA, e_err);
        chk("full2_ops", 32'(ops), 32'h09FB);
        tick(4'h5, 1'b1, 1'b1);
        tick(4'h5, 1'b0, 1'b0);
        chk("ackkey_ready", 32'(all_ready), 32'h0);
        chk("ackkey_mag",   32'(entry_mag), 32'h0);
        chk("ackkey_ops",   32'(ops), 32'h09FB);

        // clear-all with ack behaves as clear-all
        press(4'h2, e_err); press(4'hA, e_err); press(4'h3, e_err); press(4'hA, e_err);
        chk("full3_ops", 32'(ops), 32'h0302);
        tick(4'hC, 1'b1, 1'b1);
        tick(4'hC, 1'b0, 1'b0);
        chk("clrack_ops",   32'(ops), 32'h0);
        chk("clrack_ready", 32'(all_ready), 32'h0);

        // 3,enter,9 then one reset cycle
        press(4'h3, e_err); press(4'hA, e_err); press(4'h9, e_err);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mid_ops",   32'(ops), 32'h0);
        chk("rst_mid_valid", 32'(ops_valid), 32'h0);
        chk("rst_mid_mag",   32'(entry_mag), 32'h0);
        chk("rst_mid_cnt",   32'(digit_count), 32'h0);
        chk("rst_mid_index", 32'(op_index), 32'h0);

        // key held across reset release
        key_value = 4'h7; key_pressed = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_rst_no_evt", 32'(entry_mag), 32'h0);
        key_pressed = 1'b0;
        @(negedge clk);
        press(4'h7, e_err);
        chk("after_release_evt", 32'(entry_mag), 32'd7);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
